// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: response-owner encoding,
// streak counter sizing and a saturating increment helper for the stats counters.
package mem_port_arbiter_pkg;

    localparam int unsigned OWN_WIDTH = 2;

    // Which requester the read data returning next cycle belongs to
    typedef enum logic [OWN_WIDTH-1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    localparam int unsigned STREAK_MAX_DEFAULT = 4;
    localparam int unsigned STREAK_WIDTH       = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mem_arb_streak_ctr.sv
// Saturating count of consecutive data grants won against a waiting fetch.
// Raises force_if_o once the streak reaches STREAK_MAX so fetch wins the next conflict.
module mem_arb_streak_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STREAK_MAX = STREAK_MAX_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic conflict_i,
    input  logic d_gnt_i,
    output logic force_if_o
);

    localparam logic [STREAK_WIDTH-1:0] StreakMaxL = STREAK_WIDTH'(STREAK_MAX);

    logic [STREAK_WIDTH-1:0] streak_q, streak_d;

    // Count data wins during a conflict; anything else breaks the streak
    always_comb begin
        streak_d = '0;
        if (conflict_i && d_gnt_i) begin
            streak_d = (streak_q >= StreakMaxL) ? StreakMaxL : streak_q + 1'b1;
        end
    end

    // Streak register, synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign force_if_o = (streak_q >= StreakMaxL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch and load/store.
// Data has priority, bounded by a streak limiter; read data returns one cycle
// after the grant and is routed by the owner register.
// Optional build macro: MEM_ARB_STATS_EN adds conflict / fetch-wait counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STREAK_MAX = STREAK_MAX_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  stall_o
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]           conflict_cnt_o,
    output logic [15:0]           if_wait_cnt_o
`endif
);

    owner_e owner_q, owner_d;
    logic   conflict;
    logic   force_if;

    assign conflict = if_req_i & d_req_i;

    mem_arb_streak_ctr #(
        .STREAK_MAX (STREAK_MAX)
    ) u_streak (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .conflict_i (conflict),
        .d_gnt_i    (d_gnt_o),
        .force_if_o (force_if)
    );

    // Grant decision: data first unless the streak limiter hands the slot to fetch
    always_comb begin
        if_gnt_o = 1'b0;
        d_gnt_o  = 1'b0;
        if (rst_n) begin
            if (d_req_i && !(if_req_i && force_if)) begin
                d_gnt_o = 1'b1;
            end else if (if_req_i) begin
                if_gnt_o = 1'b1;
            end
        end
    end

    // Memory-side mux driven from the winner
    always_comb begin
        mem_en_o    = if_gnt_o | d_gnt_o;
        mem_we_o    = d_gnt_o & d_we_i;
        mem_addr_o  = d_gnt_o ? d_addr_i : if_addr_i;
        mem_wdata_o = d_gnt_o ? d_wdata_i : '0;
        stall_o     = rst_n & ((if_req_i & ~if_gnt_o) | (d_req_i & ~d_gnt_o));
    end

    // Remember who gets next cycle's read data; stores return nothing
    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt_o) begin
            owner_d = OWN_IF;
        end else if (d_gnt_o && !d_we_i) begin
            owner_d = OWN_DATA;
        end
    end

    // Owner register, synchronous active-low reset drops any outstanding read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Response routing; the non-owner sees zero data
    always_comb begin
        if_rvalid_o = (owner_q == OWN_IF);
        d_rvalid_o  = (owner_q == OWN_DATA);
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic [15:0] if_wait_cnt_q, if_wait_cnt_d;

    // Saturating event counters
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if_wait_cnt_d  = if_wait_cnt_q;
        if (conflict) begin
            conflict_cnt_d = sat_inc16(conflict_cnt_q);
        end
        if (if_req_i && !if_gnt_o) begin
            if_wait_cnt_d = sat_inc16(if_wait_cnt_q);
        end
    end

    // Stats registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_cnt_q <= '0;
            if_wait_cnt_q  <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
            if_wait_cnt_q  <= if_wait_cnt_d;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
    assign if_wait_cnt_o  = if_wait_cnt_q;
`endif

endmodule
